// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the bus-master family.
package wb_pkg;

  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_REQ  = 1'b1
  } wb_master_state_t;

  localparam int WB_BYTE_BITS = 8;

  // Byte-lane select width for a given data bus width.
  function automatic int wb_sel_width(input int data_width);
    return (data_width < WB_BYTE_BITS) ? 1 : data_width / WB_BYTE_BITS;
  endfunction

endpackage

// File: rtl/wb_master_nop.sv
// Wishbone B4 classic master issuing endless no-op read cycles separated by an idle gap,
// with optional ack timeout and wrap-around completion / timeout statistics.
module wb_master_nop
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int IDLE_CYCLES = 1,
  parameter int ACK_TIMEOUT = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  output logic                                cyc_o,
  output logic                                stb_o,
  input  logic                                ack_i,
  output logic [ADDR_WIDTH-1:0]               adr_o,
  output logic [DATA_WIDTH-1:0]               dat_o,
  output logic [wb_sel_width(DATA_WIDTH)-1:0] sel_o,
  output logic                                we_o,
  output logic [CNT_WIDTH-1:0]                done_cnt_o,
  output logic [CNT_WIDTH-1:0]                timeout_cnt_o
);

  localparam int IDLE_EFF = (IDLE_CYCLES < 1) ? 1 : IDLE_CYCLES;
  localparam int GAP_W    = $clog2(IDLE_EFF + 1);
  localparam int WAIT_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [GAP_W-1:0]     GAP_RELOAD = GAP_W'(IDLE_EFF);
  localparam logic [GAP_W-1:0]     GAP_ONE    = GAP_W'(1);
  localparam logic [WAIT_W-1:0]    WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST  = WAIT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam bit                   TIMEOUT_EN = (ACK_TIMEOUT > 0);

  wb_master_state_t     state_q = WB_IDLE;
  wb_master_state_t     state_d;
  logic [GAP_W-1:0]     gap_q   = GAP_RELOAD;
  logic [GAP_W-1:0]     gap_d;
  logic [WAIT_W-1:0]    wait_q  = '0;
  logic [WAIT_W-1:0]    wait_d;
  logic [CNT_WIDTH-1:0] done_q  = '0;
  logic [CNT_WIDTH-1:0] done_d;
  logic [CNT_WIDTH-1:0] tmo_q   = '0;
  logic [CNT_WIDTH-1:0] tmo_d;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    wait_d  = wait_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    case (state_q)
      WB_IDLE: begin
        wait_d = '0;
        // A gap counter at or below one means this edge ends the idle gap.
        if (gap_q <= GAP_ONE) begin
          gap_d   = '0;
          state_d = WB_REQ;
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      WB_REQ: begin
        if (ack_i) begin
          state_d = WB_IDLE;
          gap_d   = GAP_RELOAD;
          wait_d  = '0;
          done_d  = done_q + CNT_ONE;
        end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
          state_d = WB_IDLE;
          gap_d   = GAP_RELOAD;
          wait_d  = '0;
          tmo_d   = tmo_q + CNT_ONE;
        end else if (TIMEOUT_EN) begin
          wait_d = wait_q + WAIT_ONE;
        end else begin
          wait_d = wait_q;
        end
      end
      default: begin
        state_d = WB_IDLE;
        gap_d   = GAP_RELOAD;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WB_IDLE;
      gap_q   <= GAP_RELOAD;
      wait_q  <= '0;
      done_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  // Bus strobes come straight from the state flop, so ack_i never reaches them combinationally.
  assign cyc_o         = (state_q == WB_REQ);
  assign stb_o         = (state_q == WB_REQ);
  assign adr_o         = '0;
  assign dat_o         = '0;
  assign sel_o         = '0;
  assign we_o          = 1'b0;
  assign done_cnt_o    = done_q;
  assign timeout_cnt_o = tmo_q;

endmodule

// File: tb/tb_wb_master_nop.sv
// Randomized bench for wb_master_nop: two instances (no-timeout and timeout/narrow-counter)
// checked every clock against a timestamp-based model of bus ownership and statistics.
module tb_wb_master_nop;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int SW     = DW / 8;
  localparam int CW_A   = 16;
  localparam int CW_B   = 4;
  localparam int IDLE_A = 1;
  localparam int IDLE_B = 0;
  localparam int TMO_A  = 0;
  localparam int TMO_B  = 4;

  logic clk = 1'b0;
  logic rst_v [2];
  logic ack_v [2];

  logic            cyc_a, stb_a, we_a, cyc_b, stb_b, we_b;
  logic [AW-1:0]   adr_a, adr_b;
  logic [DW-1:0]   dat_a, dat_b;
  logic [SW-1:0]   sel_a, sel_b;
  logic [CW_A-1:0] done_a, tmo_a;
  logic [CW_B-1:0] done_b, tmo_b;

  wb_master_nop #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDLE_CYCLES(IDLE_A),
                  .ACK_TIMEOUT(TMO_A), .CNT_WIDTH(CW_A)) dut_a (
    .clk_i(clk), .rst_i(rst_v[0]), .cyc_o(cyc_a), .stb_o(stb_a), .ack_i(ack_v[0]),
    .adr_o(adr_a), .dat_o(dat_a), .sel_o(sel_a), .we_o(we_a),
    .done_cnt_o(done_a), .timeout_cnt_o(tmo_a)
  );

  wb_master_nop #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDLE_CYCLES(IDLE_B),
                  .ACK_TIMEOUT(TMO_B), .CNT_WIDTH(CW_B)) dut_b (
    .clk_i(clk), .rst_i(rst_v[1]), .cyc_o(cyc_b), .stb_o(stb_b), .ack_i(ack_v[1]),
    .adr_o(adr_b), .dat_o(dat_b), .sel_o(sel_b), .we_o(we_b),
    .done_cnt_o(done_b), .timeout_cnt_o(tmo_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the bus is owned from cycle start_t until a cycle ends; t counts rising edges.
  int t        [2] = '{0, 0};
  int start_t  [2];
  int done_m   [2] = '{0, 0};
  int tmo_m    [2] = '{0, 0};
  int idle_eff [2];
  int tmo_lim  [2] = '{TMO_A, TMO_B};
  int cmask    [2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
  int mode     [2];
  int hi_age   [2] = '{0, 0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t[0]);
    end
  endtask

  function automatic bit obs_stb(input int d);
    return (d == 0) ? stb_a : stb_b;
  endfunction

  // Ack policy: 0 random, 1 follow stb, 2 tied high, 3 tied low, 4 ack after 5 strobe clocks.
  function automatic bit pick_ack(input int d);
    case (mode[d])
      0:       return ($urandom_range(0, 3) == 0);
      1:       return obs_stb(d);
      2:       return 1'b1;
      3:       return 1'b0;
      4:       return obs_stb(d) && (hi_age[d] >= 5);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge(input int d, input bit rst, input bit ack);
    bit busy;
    busy = (t[d] >= start_t[d]);
    if (rst) begin
      start_t[d] = t[d] + 1 + idle_eff[d];
      done_m[d]  = 0;
      tmo_m[d]   = 0;
    end else if (busy && ack) begin
      done_m[d]++;
      start_t[d] = t[d] + 1 + idle_eff[d];
    end else if (busy && tmo_lim[d] > 0 && (t[d] + 1 - start_t[d]) == tmo_lim[d]) begin
      tmo_m[d]++;
      start_t[d] = t[d] + 1 + idle_eff[d];
    end
    t[d]++;
  endtask

  task automatic check_dut(input int d);
    logic        c, s, w;
    logic [31:0] dn, tm, zero_or;
    string       nm;
    bit          busy;
    if (d == 0) begin
      c = cyc_a; s = stb_a; w = we_a; dn = 32'(done_a); tm = 32'(tmo_a);
      zero_or = 32'(|{adr_a, dat_a, sel_a, we_a}); nm = "a";
    end else begin
      c = cyc_b; s = stb_b; w = we_b; dn = 32'(done_b); tm = 32'(tmo_b);
      zero_or = 32'(|{adr_b, dat_b, sel_b, we_b}); nm = "b";
    end
    busy = (t[d] >= start_t[d]);
    check_eq({nm, "_cyc"}, 32'(c), 32'(busy));
    check_eq({nm, "_stb"}, 32'(s), 32'(busy));
    check_eq({nm, "_done"}, dn, 32'(done_m[d] & cmask[d]));
    check_eq({nm, "_tmo"}, tm, 32'(tmo_m[d] & cmask[d]));
    check_eq({nm, "_const_zero"}, zero_or, 32'(w & 1'b0));
    hi_age[d] = s ? hi_age[d] + 1 : 0;
  endtask

  task automatic step();
    for (int d = 0; d < 2; d++) begin
      ack_v[d] = pick_ack(d);
      model_edge(d, rst_v[d], ack_v[d]);
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_dut(d);
  endtask

  initial begin
    idle_eff[0] = (IDLE_A < 1) ? 1 : IDLE_A;
    idle_eff[1] = (IDLE_B < 1) ? 1 : IDLE_B;
    start_t[0]  = idle_eff[0];
    start_t[1]  = idle_eff[1];
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    ack_v[0] = 1'b0; ack_v[1] = 1'b0;
    mode[0] = 1; mode[1] = 0;

    // Power-up without reset: slave follows stb_o.
    #1;
    check_dut(0);
    check_dut(1);
    repeat (32) step();
    check_eq("pu_done16", 32'(done_a), 32'd16);
    check_eq("pu_tmo0", 32'(tmo_a), 32'd0);

    // Reset held for three clocks on both instances.
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    repeat (3) step();
    check_eq("rst_stb_a", 32'(stb_a), 32'd0);
    check_eq("rst_done_a", 32'(done_a), 32'd0);
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;

    // ack tied high on a; ack tied low on b (timeouts, counter wrap).
    mode[0] = 2; mode[1] = 3;
    repeat (90) step();

    // Delayed ack on a; random on b.
    mode[0] = 4; mode[1] = 0;
    repeat (30) step();

    // Reset pulsed while a holds the bus.
    mode[0] = 3;
    for (int i = 0; i < 10 && !stb_a; i++) step();
    check_eq("pre_rst_stb", 32'(stb_a), 32'd1);
    rst_v[0] = 1'b1;
    step();
    rst_v[0] = 1'b0;
    check_eq("rst_mid_stb", 32'(stb_a), 32'd0);
    check_eq("rst_mid_done", 32'(done_a), 32'd0);

    // Random acks with occasional resets.
    mode[0] = 0; mode[1] = 0;
    repeat (400) begin
      rst_v[0] = ($urandom_range(0, 63) == 0);
      rst_v[1] = ($urandom_range(0, 63) == 0);
      step();
    end
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
